// File: rtl/vmem_pkg.sv
// Shared definitions for the framebuffer arbiter: geometry defaults, bus widths
// and the scanout FSM state type.
package vmem_pkg;

    localparam int unsigned H_RES_DEF = 640;
    localparam int unsigned V_RES_DEF = 480;
    localparam int unsigned PIX_W     = 24;
    localparam int unsigned ADDR_W    = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous show-ahead FIFO for prefetched scanout pixels; head is valid
// whenever empty is low, flush empties it in one cycle.
module pix_fifo #(
    parameter  int unsigned WIDTH = 24,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [LVL_W-1:0] level,
    output logic             empty
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] count;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/vmem_arbiter.sv
// Single-port framebuffer arbiter: raster-order scanout prefetch into pix_fifo,
// writer bus served in spare slots. Optional counters under VMEM_ARB_STATS_EN.
module vmem_arbiter
    import vmem_pkg::*;
#(
    parameter int unsigned       H_RES      = H_RES_DEF,
    parameter int unsigned       V_RES      = V_RES_DEF,
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter int unsigned       LOW_WM     = 4,
    parameter logic [PIX_W-1:0]  UF_COLOR   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              underflow
`ifdef VMEM_ARB_STATS_EN
    ,
    output logic [15:0]       uf_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int unsigned TOTAL = H_RES * V_RES;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = LVL_W + 1;

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [ADDR_W-1:0] scan_addr;
    logic              rd_s1;
    logic              rd_s2;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_empty;
    logic [PIX_W-1:0]  fifo_head;
    logic [SUM_W-1:0]  level;
    logic              wr_ok;
    logic              wr_in_range;
    logic              low;
    logic              room;
    logic              rd_issue;
    logic              wr_grant;
    logic              uf_event;

    pix_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_s2 && !frame_start),
        .push_data (mem_rdata),
        .pop       (pix_ready),
        .flush     (frame_start),
        .head      (fifo_head),
        .level     (fifo_level),
        .empty     (fifo_empty)
    );

    assign pix_valid   = !fifo_empty;
    assign pix_data    = fifo_empty ? UF_COLOR : fifo_head;
    assign uf_event    = pix_ready && fifo_empty;
    assign level       = SUM_W'(fifo_level) + SUM_W'(rd_s1) + SUM_W'(rd_s2);
    assign low         = (level < SUM_W'(LOW_WM));
    assign room        = (level < SUM_W'(FIFO_DEPTH));
    assign wr_in_range = (wr_addr < ADDR_W'(TOTAL));
    // wr_req is still high during the ack cycle; blocking it there avoids a double grant
    assign wr_ok       = wr_req && !wr_ack;

    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        wr_grant  = 1'b0;
        unique case (state)
            IDLE: begin
                wr_grant = wr_ok;
            end
            PRIME: begin
                if (low) begin
                    rd_issue = room;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (low) begin
                    rd_issue = room;
                end else if (wr_ok) begin
                    wr_grant = 1'b1;
                end else if (room) begin
                    rd_issue = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (frame_start) begin
            rd_issue  = 1'b0;
            state_nxt = PRIME;
        end
    end

    // rd_s1: read strobe on the RAM bus; rd_s2: its data is on mem_rdata.
    // Clearing both on frame_start drops whatever the old frame had in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            scan_addr <= '0;
            rd_s1     <= 1'b0;
            rd_s2     <= 1'b0;
            wr_ack    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            underflow <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ack <= wr_grant;
            mem_en <= rd_issue || (wr_grant && wr_in_range);
            mem_we <= wr_grant && wr_in_range;
            rd_s1  <= rd_issue;
            rd_s2  <= rd_s1 && !frame_start;
            if (wr_grant && wr_in_range) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (rd_issue) begin
                mem_addr <= scan_addr;
            end
            if (frame_start) begin
                scan_addr <= '0;
            end else if (rd_issue) begin
                scan_addr <= (scan_addr == ADDR_W'(TOTAL - 1)) ? '0 : scan_addr + 1'b1;
            end
            if (frame_start) begin
                underflow <= 1'b0;
            end else if (uf_event) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef VMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uf_count <= '0;
            wr_count <= '0;
        end else begin
            if (uf_event && (uf_count != '1)) begin
                uf_count <= uf_count + 1'b1;
            end
            if (wr_grant) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vmem_arbiter.sv
// Scoreboard bench for vmem_arbiter on a small 16x4 framebuffer with a RAM model.
module tb_vmem_arbiter;

    localparam int unsigned HR    = 16;
    localparam int unsigned VR    = 4;
    localparam int unsigned TOTAL = HR * VR;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LWM   = 4;
    localparam logic [23:0] UFC   = 24'hDEAD01;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_ready = 1'b0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        wr_req = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata = '0;
    logic        underflow;
`ifdef VMEM_ARB_STATS_EN
    logic [15:0] uf_count;
    logic [15:0] wr_count;
`endif

    vmem_arbiter #(
        .H_RES      (HR),
        .V_RES      (VR),
        .FIFO_DEPTH (DEPTH),
        .LOW_WM     (LWM),
        .UF_COLOR   (UFC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .underflow   (underflow)
`ifdef VMEM_ARB_STATS_EN
        ,
        .uf_count    (uf_count),
        .wr_count    (wr_count)
`endif
    );

    typedef struct packed {
        logic        in_range;
        logic [18:0] addr;
        logic [23:0] data;
    } wr_exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          pop_cnt = 0;
    int          reads_seen = 0;
    int          uf_events = 0;
    int          uf_rst = 0;
    int          acks_rst = 0;
    bit          uf_model = 1'b0;
    logic [23:0] ram [TOTAL];
    logic [23:0] fb [TOTAL];
    logic [23:0] pix_log [256];
    logic [23:0] pix_q [$];
    wr_exp_t     wr_q [$];
    logic [23:0] exp_pix;
    wr_exp_t     exp_wr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_evt(input string name, input string act, input string req);
        checks++;
        failures++;
        $display("FAIL %s actual=%s required=%s", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RAM: write on strobe, read data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_en && (mem_addr < 19'(TOTAL))) begin
            if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[5:0]];
        end
    end

    // Monitor: pixel stream, underflow flag and write acknowledgements.
    always @(negedge clk) begin
        if (rst) begin
            check("underflow", 32'(underflow), 32'(uf_model));
            if (pix_ready && !frame_start) begin
                if (pix_valid) begin
                    if (pix_q.size() == 0) begin
                        fail_evt("pix_unexpected", "pixel", "none");
                    end else begin
                        exp_pix = pix_q.pop_front();
                        check("pix_data", 32'(pix_data), 32'(exp_pix));
                        if (pop_cnt < 256) pix_log[pop_cnt] = pix_data;
                        pop_cnt++;
                    end
                end else begin
                    check("uf_color", 32'(pix_data), 32'(UFC));
                    uf_events++;
                    uf_rst++;
                end
            end
            if (frame_start) uf_model = 1'b0;
            else if (pix_ready && !pix_valid) uf_model = 1'b1;

            if (wr_ack) begin
                if (wr_q.size() == 0) begin
                    fail_evt("wr_ack_unexpected", "ack", "none");
                end else begin
                    exp_wr = wr_q.pop_front();
                    acks_rst++;
                    if (exp_wr.in_range) begin
                        check("wr_strobe", 32'({mem_en, mem_we}), 32'h3);
                        check("wr_mem_addr", 32'(mem_addr), 32'(exp_wr.addr));
                        check("wr_mem_data", 32'(mem_wdata), 32'(exp_wr.data));
                    end else begin
                        check("oor_no_access", 32'(mem_en), 32'h0);
                    end
                end
            end else if (mem_en && mem_we) begin
                fail_evt("write_without_ack", "write", "none");
            end
            if (mem_en && !mem_we) begin
                reads_seen++;
                check("rd_addr_range", 32'(mem_addr < 19'(TOTAL)), 32'h1);
            end
        end
    end

    // Each frame_start rebuilds the expected pixel stream from the reference framebuffer.
    task automatic do_frame_start();
        pix_ready   = 1'b0;
        frame_start = 1'b1;
        pix_q.delete();
        for (int k = 0; k < 2 * TOTAL + 8; k++) pix_q.push_back(fb[k % TOTAL]);
        pop_cnt = 0;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wr_one(input logic [18:0] a, input logic [23:0] d, output int lat);
        wr_exp_t e;
        e.in_range = (a < 19'(TOTAL));
        e.addr     = a;
        e.data     = d;
        wr_q.push_back(e);
        if (e.in_range) fb[a[5:0]] = d;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        lat     = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (wr_ack) break;
            if (lat > 60) begin
                fail_evt("wr_timeout", "no_ack", "ack");
                break;
            end
        end
        @(posedge clk);
        #1;
        wr_req = 1'b0;
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0;
        int u0;
        int t0;
        logic [18:0] a;

        for (int i = 0; i < int'(TOTAL); i++) begin
            ram[i] = 24'(i);
            fb[i]  = 24'(i);
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_pix_valid", 32'(pix_valid), 32'h0);
        check("rst_pix_data", 32'(pix_data), 32'(UFC));
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_wr_ack", 32'(wr_ack), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        step();
        rst = 1'b1;
        step();

        // IDLE: every request granted at once, no scanout reads
        for (int i = 0; i < 5; i++) begin
            if (i == 2) a = 19'(TOTAL + $urandom_range(0, 4000));
            else        a = 19'($urandom_range(0, TOTAL - 1));
            wr_one(a, 24'($urandom), lat);
            check("idle_wr_latency", 32'(lat), 32'd2);
        end
        step();
        check("idle_no_reads", 32'(reads_seen), 32'h0);

        // Prime with no consumer, then stream one pixel per cycle from cycle 20
        do_frame_start();
        repeat (19) step();
        check("primed_valid", 32'(pix_valid), 32'h1);
        u0 = uf_events;
        pix_ready = 1'b1;
        repeat (40) step();
        pix_ready = 1'b0;
        check("main_pops", 32'(pop_cnt), 32'd40);
        check("main_no_uf", 32'(uf_events - u0), 32'h0);

        // Writer stalls during PRIME until the watermark is reached
        do_frame_start();
        r0 = reads_seen;
        wr_one(19'(TOTAL - 1), 24'($urandom), lat);
        check("prime_reads_before_ack", 32'(reads_seen - r0 >= int'(LWM)), 32'h1);
        check("prime_ack_not_immediate", 32'(lat > 2), 32'h1);

        // Consumer on an empty FIFO: UF_COLOR, sticky flag, cleared by next frame
        do_frame_start();
        u0 = uf_events;
        pix_ready = 1'b1;
        repeat (30) step();
        pix_ready = 1'b0;
        check("uf_seen", 32'(uf_events > u0), 32'h1);
        check("uf_sticky", 32'(underflow), 32'h1);
        do_frame_start();
        step();
        check("uf_cleared", 32'(underflow), 32'h0);

        // RUN with a continuous writer and a half-rate consumer
        repeat (10) step();
        pix_ready = 1'b1;
        repeat (8) step();
        pix_ready = 1'b0;
        u0 = uf_events;
        fork
            begin
                for (int i = 0; i < 44; i++) begin
                    pix_ready = (i % 2 == 0);
                    step();
                end
                pix_ready = 1'b0;
            end
            begin
                t0 = cyc;
                for (int i = 0; i < 18; i++) begin
                    if ($urandom_range(0, 5) == 0) a = 19'(TOTAL + $urandom_range(0, 9000));
                    else                           a = 19'($urandom_range(0, pop_cnt - 1));
                    wr_one(a, 24'($urandom), lat);
                end
                check("run_wr_rate", 32'(cyc - t0 <= 40), 32'h1);
            end
        join
        check("run_no_uf", 32'(uf_events - u0), 32'h0);

        // Full-speed scan past the end of the frame: address wraps to 0
        do_frame_start();
        repeat (20) step();
        pix_ready = 1'b1;
        repeat (TOTAL + 6) step();
        check("wrap_pops", 32'(pop_cnt), 32'(TOTAL + 6));
        check("wrap_pixel", 32'(pix_log[TOTAL]), 32'(fb[0]));

        // frame_start right after consumption, with reads still outstanding
        do_frame_start();
        repeat (3) step();
        pix_ready = 1'b1;
        repeat (12) step();
        pix_ready = 1'b0;
        check("restart_first", 32'(pix_log[0]), 32'(fb[0]));

        // Reset asserted mid-frame
        do_frame_start();
        repeat (10) step();
        pix_ready = 1'b1;
        repeat (5) step();
        pix_ready = 1'b0;
        rst = 1'b0;
        #1;
        pix_q.delete();
        uf_model = 1'b0;
        check("midrst_pix_valid", 32'(pix_valid), 32'h0);
        check("midrst_pix_data", 32'(pix_data), 32'(UFC));
        check("midrst_mem_en", 32'(mem_en), 32'h0);
        check("midrst_underflow", 32'(underflow), 32'h0);
        uf_rst   = 0;
        acks_rst = 0;
        repeat (3) step();
        rst = 1'b1;
        step();
        do_frame_start();
        repeat (20) step();
        pix_ready = 1'b1;
        repeat (5) step();
        pix_ready = 1'b0;
        check("post_rst_first", 32'(pix_log[0]), 32'(fb[0]));
        check("post_rst_pops", 32'(pop_cnt), 32'd5);
        step();

`ifdef VMEM_ARB_STATS_EN
        check("stats_wr_count", 32'(wr_count), 32'(acks_rst));
        check("stats_uf_count", 32'(uf_count), 32'(uf_rst));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
